// File: rtl/inemo_spi_slave_if.sv
// SPI pin bundle for inemo_spi_slave: slave select, clock, data-in and
// the data-ready interrupt. MISO is kept as a separate tri-state port on the
// slave so that it resolves as a plain net in the enclosing design.
interface inemo_spi_slave_if;
    logic SS_n;
    logic SCLK;
    logic MOSI;
    logic INT;

    modport slave (
        input  SS_n,
        input  SCLK,
        input  MOSI,
        output INT
    );

    modport master (
        output SS_n,
        output SCLK,
        output MOSI,
        input  INT
    );
endinterface

// File: rtl/inemo_spi_slave.sv
// inemo_spi_slave: mode-0 SPI register slave for an inertial sensor front end.
// The SPI pins are oversampled in clk (clk >= 8x SCLK). A frame is a command
// byte (bit7 = read, bits[6:0] = address) followed by one data byte.
// Supported addresses: WHO_AM_I at 0x0F, a 32x8 register file at 0x00-0x1F,
// and channel low/high bytes at 0x22+2k/0x23+2k. The high byte is read from
// a shadow captured when the low byte is read.
// A free-running period counter runs while the measurement-enable registers
// are set. INT is raised on every counter wrap and cleared by reading 0x22.
// Optional build macro INEMO_BURST_EN: the frame continues past the first
// data byte with the address auto-incrementing. Without it, the frame ends
// after 16 bits.
module inemo_spi_slave #(
    parameter int unsigned NUM_CH   = 3,
    parameter int unsigned PERIOD_W = 11,
    parameter logic [7:0]  WHO_AM_I = 8'h6A
) (
    input  logic                  clk,
    input  logic                  rst_n,
    inemo_spi_slave_if.slave      spi,
    output tri                    MISO,
    input  logic [16*NUM_CH-1:0]  ch_data
);

    typedef enum logic [1:0] {ST_IDLE, ST_CMD, ST_DATA} state_t;

    state_t              state_q;
    logic [2:0]          ss_q;
    logic [2:0]          sclk_q;
    logic [1:0]          mosi_q;
    logic [2:0]          bit_cnt_q;
    logic [6:0]          rx_q;
    logic [7:0]          tx_q;
    logic                rw_q;
    logic [6:0]          addr_q;
    logic                load_q;
    logic                int_clr_q;
    logic                int_q;
    logic [PERIOD_W-1:0] per_cnt_q;
    logic [7:0]          shadow_q [NUM_CH];
    logic [7:0]          regs_q   [32];

    logic       ss_fall;
    logic       ss_rise;
    logic       sclk_rise;
    logic       sclk_fall;
    logic [7:0] rx_byte;
    logic [7:0] resp_d;
    logic       wr_en;
    logic       meas_en;

    function automatic logic [6:0] ch_lo_addr(input int unsigned k);
        return 7'(34 + 2 * k);
    endfunction

    assign ss_fall   = ss_q[2] & ~ss_q[1];
    assign ss_rise   = ~ss_q[2] & ss_q[1];
    assign sclk_rise = ~sclk_q[2] & sclk_q[1];
    assign sclk_fall = sclk_q[2] & ~sclk_q[1];
    assign rx_byte   = {rx_q, mosi_q[1]};

    assign wr_en = (state_q == ST_DATA) && sclk_rise && !ss_fall && !ss_rise &&
                   (bit_cnt_q == 3'd7) && !rw_q && (addr_q[6:5] == 2'b00);

    assign meas_en = (regs_q[13] == 8'h02) && (regs_q[17] == 8'h60);

    assign MISO     = spi.SS_n ? 1'bz : tx_q[7];
    assign spi.INT  = int_q;

    // Two-flop pin synchronizers plus one delay stage for edge detection.
    // Cleared in reset so a slave select already low at release is not seen as a fall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ss_q   <= '0;
            sclk_q <= '0;
            mosi_q <= '0;
        end else begin
            ss_q   <= {ss_q[1:0], spi.SS_n};
            sclk_q <= {sclk_q[1:0], spi.SCLK};
            mosi_q <= {mosi_q[0], spi.MOSI};
        end
    end

    // Response byte for the current command; WHO_AM_I shadows register 0x0F.
    always_comb begin
        resp_d = 8'h00;
        if (!rw_q) begin
            resp_d = 8'hA5;
        end else if (addr_q == 7'h0F) begin
            resp_d = WHO_AM_I;
        end else if (addr_q[6:5] == 2'b00) begin
            resp_d = regs_q[addr_q[4:0]];
        end else begin
            for (int unsigned k = 0; k < NUM_CH; k++) begin
                if (addr_q == ch_lo_addr(k))
                    resp_d = ch_data[16*k +: 8];
                else if (addr_q == ch_lo_addr(k) + 7'd1)
                    resp_d = shadow_q[k];
            end
        end
    end

    // Frame state machine: bit counting, rx/tx shifting, response load and shadow capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            bit_cnt_q <= '0;
            rx_q      <= '0;
            tx_q      <= '0;
            rw_q      <= 1'b0;
            addr_q    <= '0;
            load_q    <= 1'b0;
            int_clr_q <= 1'b0;
            for (int unsigned k = 0; k < NUM_CH; k++) shadow_q[k] <= '0;
        end else begin
            int_clr_q <= 1'b0;
            if (ss_fall) begin
                state_q   <= ST_CMD;
                bit_cnt_q <= '0;
                rx_q      <= '0;
                tx_q      <= '0;
                load_q    <= 1'b0;
            end else if (ss_rise) begin
                state_q   <= ST_IDLE;
                bit_cnt_q <= '0;
                rx_q      <= '0;
                load_q    <= 1'b0;
            end else begin
                if (sclk_rise) begin
                    case (state_q)
                        ST_CMD: begin
                            rx_q      <= rx_byte[6:0];
                            bit_cnt_q <= bit_cnt_q + 3'd1;
                            if (bit_cnt_q == 3'd7) begin
                                rw_q      <= rx_byte[7];
                                addr_q    <= rx_byte[6:0];
                                load_q    <= 1'b1;
                                state_q   <= ST_DATA;
                                int_clr_q <= (rx_byte == 8'hA2);
                            end
                        end
                        ST_DATA: begin
                            rx_q      <= rx_byte[6:0];
                            bit_cnt_q <= bit_cnt_q + 3'd1;
                            if (bit_cnt_q == 3'd7) begin
`ifdef INEMO_BURST_EN
                                addr_q <= addr_q + 7'd1;
                                load_q <= 1'b1;
`else
                                state_q <= ST_IDLE;
`endif
                            end
                        end
                        default: ;
                    endcase
                end
                // Falls keep shifting after the frame ends, so trailing bits read as 0.
                if (sclk_fall) begin
                    if (load_q) begin
                        tx_q   <= resp_d;
                        load_q <= 1'b0;
                        for (int unsigned k = 0; k < NUM_CH; k++) begin
                            if (rw_q && (addr_q == ch_lo_addr(k)))
                                shadow_q[k] <= ch_data[16*k+8 +: 8];
                        end
                    end else begin
                        tx_q <= {tx_q[6:0], 1'b0};
                    end
                end
            end
        end
    end

    // Register file, written when the last data bit of a write byte is sampled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < 32; i++) regs_q[i] <= '0;
        end else if (wr_en) begin
            regs_q[addr_q[4:0]] <= rx_byte;
        end
    end

    // Update-period counter and data-ready interrupt; a clear request beats a set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            per_cnt_q <= '0;
            int_q     <= 1'b0;
        end else begin
            per_cnt_q <= meas_en ? per_cnt_q + 1'b1 : '0;
            if (int_clr_q)
                int_q <= 1'b0;
            else if (meas_en && (&per_cnt_q))
                int_q <= 1'b1;
        end
    end

endmodule

// File: doc/inemo_spi_slave.md
INEMO_SPI_SLAVE -- requirements
Module: inemo_spi_slave

Interface
REQ-001 SHALL have parameter NUM_CH, default 3: number of 16-bit inertial channels (1..8).
REQ-002 SHALL have parameter PERIOD_W, default 11: width of the update-period counter.
REQ-003 SHALL have parameter WHO_AM_I, default 8'h6A: identity byte returned at address 0x0F.
REQ-004 SHALL have ports: clk input 1 (system clock); rst_n input 1 (reset, asynchronous, active-low).
REQ-005 SHALL have ports: SS_n input 1 (active-low slave select, asynchronous pin); SCLK input 1 (SPI clock, asynchronous pin); MOSI input 1 (serial data in).
REQ-006 SHALL have ports: MISO output 1 (serial data out, tri-state); INT output 1 (data-ready interrupt); ch_data input 16*NUM_CH (channel k at bits [16k+15:16k]).

Function
REQ-007 SHALL pass SS_n, SCLK and MOSI through 2-flop synchronizers in clk; SCLK edges SHALL be detected on synchronized values; clk SHALL be >= 8x SCLK.
REQ-008 SPI mode 0: MOSI sampled on synchronized SCLK rise; MISO changes only on synchronized SCLK fall; MSB first.
REQ-009 State machine IDLE, CMD, DATA: IDLE->CMD on synchronized SS_n fall (bit counter cleared); CMD->DATA after 8th rise; DATA->IDLE after 16th rise or SS_n rise.
REQ-010 Command byte: bit7 = 1 read / 0 write; bits[6:0] = register address.
REQ-011 On the first SCLK fall after the 8th rise, tx shift register SHALL load the response byte; later falls shift left by one, filling 0.
REQ-012 MISO SHALL be Z while the SS_n pin is high, else tx shift register bit 7.
REQ-013 Response for write commands SHALL be 8'hA5.
REQ-014 Read map: 0x0F->WHO_AM_I; 0x22+2k->ch k low byte; 0x23+2k->ch k high byte (k<NUM_CH); 0x00-0x1F->register file; all else 8'h00.
REQ-015 Reading ch k low byte SHALL latch ch k high byte into a shadow register; a following read of 0x23+2k SHALL return the shadow, not live data.
REQ-016 Register file: 32x8, addresses 0x00-0x1F; a write SHALL commit on the 16th SCLK rise; writes to other addresses SHALL be ignored.
REQ-017 SS_n rise before a data byte completes SHALL abort: partial byte discarded, no write, state IDLE.
REQ-018 Measurement enable SHALL be (reg 0x0D == 8'h02) && (reg 0x11 == 8'h60).
REQ-019 When enabled, PERIOD_W counter SHALL increment every clk and wrap; when disabled it SHALL hold at 0.
REQ-020 INT SHALL set on the clk cycle the counter is all-ones and stay set until cleared.
REQ-021 INT SHALL clear on the clk after the command byte of a read of 0x22 (ch 0 low) completes; if set and clear coincide, clear SHALL win.
REQ-022 Bits beyond 16 in a frame SHALL be ignored (MISO 0, no writes) unless INEMO_BURST_EN is defined.

Reset
REQ-023 On rst_n low: state IDLE, counters 0, tx/rx shift registers 0, shadows 0, register file 0, INT 0; MISO Z if SS_n high, else 0.
REQ-024 Reset mid-frame SHALL abort the frame with no write; after rst_n rises the block SHALL ignore the frame until the next SS_n fall.

Configuration
REQ-025 Macro INEMO_BURST_EN defined: after each data byte, the address auto-increments (7-bit wrap) and the frame continues until SS_n rises; reads load the next response per REQ-011 and REQ-014; writes commit on each 8th data-bit rise.
REQ-026 INEMO_BURST_EN undefined: frames are exactly 16 bits per REQ-009 and REQ-022.

Verification
REQ-027 Reset, SS_n high -> INT 0, MISO Z; read 0x8F -> MISO byte 8'h6A.
REQ-028 Write 0x0D=0x02, then 0x11=0x60 -> INT rises 2^11 clks after the second write commits; read 0xA2 -> INT falls; INT rises again 2048 clks after the prior rise.
REQ-029 ch_data ch0=16'h1234; read 0xA2 (returns 0x34); ch0 changed to 16'hABCD; read 0xA3 -> returns 0x12.
REQ-030 Write 0x05=0x77 with SS_n raised after 12 bits -> later read 0x85 returns 0x00; full write -> read returns 0x77.
REQ-031 INEMO_BURST_EN defined: 40-bit frame 0xA2 with ch0=16'h1234, ch1=16'h5678 -> MISO bytes 0x34,0x12,0x78,0x56; undefined -> bits 17-40 read 0.
REQ-032 rst_n pulsed low mid-write of 0x0D=0x02 -> reg 0x0D reads 0x00; state IDLE.
